// File: rtl/hdg_pid_pkg.sv
// hdg_pid_pkg: shared widths, clamp bounds and the saturation helper
// used by the heading-hold PID controller.
package hdg_pid_pkg;

    localparam int HDG_W   = 12;
    localparam int ERR_W   = 10;
    localparam int DDIFF_W = 7;
    localparam int INTEG_W = 16;
    localparam int PID_W   = 14;
    localparam int SPD_W   = 12;

    localparam logic signed [15:0] ERR_MAX   = 16'sd511;
    localparam logic signed [15:0] ERR_MIN   = -16'sd512;
    localparam logic signed [15:0] DDIFF_MAX = 16'sd63;
    localparam logic signed [15:0] DDIFF_MIN = -16'sd64;

    typedef logic signed [ERR_W-1:0] err_t;

    // Clamp a 16-bit signed value into [lo, hi]; callers truncate the
    // result to the width of the bound they passed.
    function automatic logic signed [15:0] sat_signed(
        input logic signed [15:0] val,
        input logic signed [15:0] lo,
        input logic signed [15:0] hi
    );
        logic signed [15:0] res;
        if (val > hi) begin
            res = hi;
        end else if (val < lo) begin
            res = lo;
        end else begin
            res = val;
        end
        return res;
    endfunction

endpackage

// File: rtl/hdg_pid_dq.sv
// hdg_pid_dq: shift queue of past errors feeding the derivative term.
// Entry 0 is the newest sample; the oldest entry is the derivative
// reference. Shifts only when push is high.
module hdg_pid_dq
    import hdg_pid_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  err_t              din,
    output err_t              oldest
);

    err_t entries_q [DEPTH];
    err_t entries_d [DEPTH];

    // Next-state: shift toward the oldest slot on push, otherwise hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                entries_d[i] = entries_q[i-1];
            end
            entries_d[0] = din;
        end else begin
            entries_d[0] = entries_q[0];
        end
    end

    // Queue storage, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    assign oldest = entries_q[DEPTH-1];

endmodule

// File: rtl/hdg_pid.sv
// hdg_pid: heading-hold PID controller. Stage 1 registers the clamped
// heading error; stage 2 forms P+I+D and registers wheel speeds.
// Optional build macro HDG_PID_ANTIWINDUP_EN: the integrator also holds
// while the previous unclamped |PID>>>3| exceeds 511.
module hdg_pid
    import hdg_pid_pkg::*;
#(
    parameter int                D_QUEUE_DEPTH = 2,
    parameter logic signed [3:0] P_COEF        = 4'sh3,
    parameter logic signed [4:0] D_COEF        = 5'sh0E
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    err_vld,
    input  logic signed [HDG_W-1:0] heading,
    input  logic signed [HDG_W-1:0] dsrd_hdg,
    input  logic                    moving,
    input  logic [9:0]              frwrd,
    output logic signed [SPD_W-1:0] lft_spd,
    output logic signed [SPD_W-1:0] rght_spd,
    output logic                    out_vld
);

    // Stage 1 state
    err_t                     err_q, err_d;
    logic                     v1_q, v1_d;
    logic signed [HDG_W:0]    err_raw_s;
    err_t                     err_sat_s;

    // Stage 2 state and intermediates
    logic signed [INTEG_W-1:0] integ_q, integ_d;
    logic signed [INTEG_W-1:0] sum_s;
    logic                      ovf_s;
    logic                      aw_hold_s;
    logic signed [PID_W-1:0]   p_s, i_s, d_s, pid_s;
    logic signed [ERR_W:0]     ddiff_raw_s;
    logic signed [DDIFF_W-1:0] ddiff_s;
    logic signed [10:0]        pid_shr_s;
    logic signed [SPD_W-1:0]   base_s;
    logic signed [SPD_W-1:0]   lft_q, lft_d, rght_q, rght_d;
    logic                      out_vld_q, out_vld_d;
    logic                      push_s;
    err_t                      prev_s;

    // Stage 1: widen, subtract and clamp the heading error.
    always_comb begin
        err_raw_s = {heading[HDG_W-1], heading} - {dsrd_hdg[HDG_W-1], dsrd_hdg};
        err_sat_s = ERR_W'(sat_signed({{3{err_raw_s[HDG_W]}}, err_raw_s}, ERR_MIN, ERR_MAX));
        v1_d      = err_vld;
        if (err_vld) begin
            err_d = err_sat_s;
        end else begin
            err_d = err_q;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            err_q <= err_d;
            v1_q  <= v1_d;
        end
    end

    hdg_pid_dq #(
        .DEPTH (D_QUEUE_DEPTH)
    ) u_dq (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_s),
        .din    (err_q),
        .oldest (prev_s)
    );

`ifdef HDG_PID_ANTIWINDUP_EN
    logic signed [10:0] pid_shr_q, pid_shr_d;

    // Remember the last unclamped PID>>>3 for the windup check.
    always_comb begin
        if (v1_q && moving) begin
            pid_shr_d = pid_shr_s;
        end else begin
            pid_shr_d = pid_shr_q;
        end
        aw_hold_s = (pid_shr_q > 11'sd511) || (pid_shr_q < -11'sd511);
    end

    // Windup reference register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_shr_q <= '0;
        end else begin
            pid_shr_q <= pid_shr_d;
        end
    end
`else
    assign aw_hold_s = 1'b0;
`endif

    // Stage 2: integrator with overflow hold, P/I/D terms and speeds.
    always_comb begin
        sum_s = integ_q + $signed({{(INTEG_W-ERR_W){err_q[ERR_W-1]}}, err_q});
        ovf_s = (integ_q[INTEG_W-1] == err_q[ERR_W-1]) &&
                (sum_s[INTEG_W-1] != integ_q[INTEG_W-1]);

        if (!moving) begin
            integ_d = '0;
        end else if (v1_q && !ovf_s && !aw_hold_s) begin
            integ_d = sum_s;
        end else begin
            integ_d = integ_q;
        end

        p_s = $signed({{(PID_W-ERR_W){err_q[ERR_W-1]}}, err_q}) *
              $signed({{(PID_W-4){P_COEF[3]}}, P_COEF});
        i_s = $signed({{2{integ_d[INTEG_W-1]}}, integ_d[INTEG_W-1:4]});

        ddiff_raw_s = {err_q[ERR_W-1], err_q} - {prev_s[ERR_W-1], prev_s};
        ddiff_s     = DDIFF_W'(sat_signed({{(16-ERR_W-1){ddiff_raw_s[ERR_W]}}, ddiff_raw_s},
                                          DDIFF_MIN, DDIFF_MAX));
        d_s = $signed({{(PID_W-DDIFF_W){ddiff_s[DDIFF_W-1]}}, ddiff_s}) *
              $signed({{(PID_W-5){D_COEF[4]}}, D_COEF});

        pid_s     = p_s + i_s + d_s;
        pid_shr_s = 11'(pid_s >>> 3);
        base_s    = $signed({2'b00, frwrd});
        push_s    = v1_q && moving;
        out_vld_d = v1_q;

        if (v1_q && moving) begin
            lft_d  = base_s + $signed({pid_shr_s[10], pid_shr_s});
            rght_d = base_s - $signed({pid_shr_s[10], pid_shr_s});
        end else if (v1_q) begin
            lft_d  = '0;
            rght_d = '0;
        end else begin
            lft_d  = lft_q;
            rght_d = rght_q;
        end
    end

    // Stage 2 registers: integrator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_q   <= '0;
            lft_q     <= '0;
            rght_q    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            integ_q   <= integ_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign out_vld  = out_vld_q;

endmodule
